// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types for the VRAM arbiter and its read-return pipeline.
// Used by vram_arbiter and vram_read_pipe (optional stats feature: VRAM_ARB_STATS_EN).
package vram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    // Travels alongside an access so the returning read data can be steered.
    typedef struct packed {
        owner_t owner;
        logic   we;
    } access_tag_t;

    localparam int STATS_W = 16;

endpackage

// File: rtl/vram_read_pipe.sv
// vram_read_pipe: tags each RAM access with its owner and steers ram_rdata back to
// the display or CPU side with a fixed latency of three edges from arbitration.
module vram_read_pipe
    import vram_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  access_tag_t       grant_tag,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata
);

    access_tag_t tag_p0;
    access_tag_t tag_p1;

    // E0: tag captured together with ram_addr/ram_we; E1: RAM performs the read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_p0 <= '{owner: OWN_NONE, we: 1'b0};
            tag_p1 <= '{owner: OWN_NONE, we: 1'b0};
        end else begin
            tag_p0 <= grant_tag;
            tag_p1 <= tag_p0;
        end
    end

    // E2: ram_rdata is valid now; route it and raise the completion pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_valid <= 1'b0;
            disp_data  <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            disp_valid <= (tag_p1.owner == OWN_DISP);
            cpu_ack    <= (tag_p1.owner == OWN_CPU);
            if (tag_p1.owner == OWN_DISP) begin
                disp_data <= ram_rdata;
            end
            if ((tag_p1.owner == OWN_CPU) && !tag_p1.we) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: one single-port VRAM shared by display scanout (priority) and a CPU port
// with a bounded-wait override. Define VRAM_ARB_STATS_EN to add the collision counter.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               display_on,
    input  logic               disp_req,
    input  logic [ADDR_W-1:0]  disp_addr,
    output logic               disp_valid,
    output logic [DATA_W-1:0]  disp_data,
    output logic               disp_miss,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_ack,
    output logic [DATA_W-1:0]  cpu_rdata,
`ifdef VRAM_ARB_STATS_EN
    input  logic               frame_start,
    output logic [STATS_W-1:0] conflict_cnt,
`endif
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    function automatic logic [WAIT_W-1:0] sat_wait_inc(input logic [WAIT_W-1:0] v);
        return (v == WAIT_LIMIT) ? v : v + 1'b1;
    endfunction

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    logic        disp_elig;
    logic        cpu_contend;
    logic        wait_expired;
    logic        cpu_grant;
    logic        disp_grant;
    logic        disp_drop;
    access_tag_t grant_tag;

    assign disp_elig    = disp_req & display_on;
    assign cpu_contend  = (state == IDLE) & cpu_req;
    assign wait_expired = (wait_cnt == WAIT_LIMIT);
    // Display keeps priority until the CPU has waited MAX_WAIT cycles.
    assign cpu_grant    = cpu_contend & (~disp_elig | wait_expired);
    assign disp_grant   = disp_elig & ~cpu_grant;
    assign disp_drop    = disp_elig & cpu_grant;

    always_comb begin
        grant_tag = '{owner: OWN_NONE, we: 1'b0};
        if (cpu_grant) begin
            grant_tag = '{owner: OWN_CPU, we: cpu_we};
        end else if (disp_grant) begin
            grant_tag = '{owner: OWN_DISP, we: 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // A held cpu_req stays in PEND until its ack so it is never granted twice.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            IDLE: begin
                if (cpu_grant) begin
                    state_nxt = PEND;
                    wait_nxt  = '0;
                end else if (cpu_req) begin
                    wait_nxt = sat_wait_inc(wait_cnt);
                end else begin
                    wait_nxt = '0;
                end
            end
            PEND: begin
                wait_nxt = '0;
                if (cpu_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                wait_nxt  = '0;
            end
        endcase
    end

    // E0: winner registered onto the RAM port; address holds when nobody is granted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            disp_miss <= 1'b0;
        end else begin
            disp_miss <= disp_drop;
            ram_we    <= 1'b0;
            if (cpu_grant) begin
                ram_addr <= cpu_addr;
                ram_we   <= cpu_we;
                if (cpu_we) begin
                    ram_wdata <= cpu_wdata;
                end
            end else if (disp_grant) begin
                ram_addr <= disp_addr;
            end
        end
    end

    vram_read_pipe #(
        .DATA_W (DATA_W)
    ) u_read_pipe (
        .clk        (clk),
        .reset      (reset),
        .grant_tag  (grant_tag),
        .ram_rdata  (ram_rdata),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata)
    );

`ifdef VRAM_ARB_STATS_EN
    function automatic logic [STATS_W-1:0] sat_stats_inc(input logic [STATS_W-1:0] v);
        return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // A collision is a cycle where both sides actually contend for arbitration.
    logic collide;
    assign collide = disp_elig & cpu_contend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if (frame_start) begin
            conflict_cnt <= '0;
        end else if (collide) begin
            conflict_cnt <= sat_stats_inc(conflict_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural single-port RAM.
// Stats checks are compiled in when VRAM_ARB_STATS_EN is defined.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b1;
    logic        display_on = 1'b0;
    logic        disp_req = 1'b0;
    logic [9:0]  disp_addr = '0;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_miss;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
`ifdef VRAM_ARB_STATS_EN
    logic        frame_start = 1'b0;
    logic [15:0] conflict_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int dv_seen = 0;
    int miss_seen = 0;

    typedef struct {
        logic       we;
        logic [7:0] data;
    } cpu_exp_t;

    logic [7:0] disp_exp[$];
    cpu_exp_t   cpu_exp[$];
    logic [7:0] shadow[0:1023];
    logic [7:0] mem[0:1023];
    logic [7:0] mon_e;
    cpu_exp_t   mon_c;

    vram_arbiter #(
        .ADDR_W   (10),
        .DATA_W   (8),
        .MAX_WAIT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .display_on   (display_on),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_valid   (disp_valid),
        .disp_data    (disp_data),
        .disp_miss    (disp_miss),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
`ifdef VRAM_ARB_STATS_EN
        .frame_start  (frame_start),
        .conflict_cnt (conflict_cnt),
`endif
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int a);
        if (a == 5) return 8'hA5;
        return 8'(a * 37 + 11);
    endfunction

    // Synchronous single-port RAM, read-first, data one cycle after the address.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    // Scoreboard: pop an expectation for every returned fetch or CPU completion.
    always @(negedge clk) begin
        if (reset && disp_miss) miss_seen++;
        if (reset && disp_valid) begin
            dv_seen++;
            vectors++;
            if (disp_exp.size() == 0) begin
                miscompares++;
                $display("FAIL disp_unexpected: disp_valid=1 data=%h, required no valid", disp_data);
            end else begin
                mon_e = disp_exp.pop_front();
                if (disp_data !== mon_e) begin
                    miscompares++;
                    $display("FAIL disp_data: got %h, required %h", disp_data, mon_e);
                end
            end
        end
        if (reset && cpu_ack) begin
            vectors++;
            if (cpu_exp.size() == 0) begin
                miscompares++;
                $display("FAIL cpu_unexpected: cpu_ack=1 rdata=%h, required no ack", cpu_rdata);
            end else begin
                mon_c = cpu_exp.pop_front();
                if (!mon_c.we && (cpu_rdata !== mon_c.data)) begin
                    miscompares++;
                    $display("FAIL cpu_rdata: got %h, required %h", cpu_rdata, mon_c.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_start(input logic we, input logic [9:0] a, input logic [7:0] d);
        cpu_exp_t e;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        e.we      = we;
        e.data    = shadow[a];
        if (we) shadow[a] = d;
        cpu_exp.push_back(e);
    endtask

    task automatic wait_ack(output int lat);
        lat = -1;
        for (int n = 1; n <= 64; n++) begin
            step();
            if (cpu_ack === 1'b1) begin
                lat = n;
                break;
            end
        end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        load = 1'b0;
        step();
        vectors++;
        if ({ram_addr, ram_we, ram_wdata, disp_valid, disp_data, disp_miss, cpu_ack, cpu_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {ram_addr, ram_we, ram_wdata, disp_valid, disp_data, disp_miss, cpu_ack, cpu_rdata});
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_disp_fetch();
        display_on = 1'b1;
        disp_req   = 1'b1;
        disp_addr  = 10'h005;
        disp_exp.push_back(shadow[5]);
        step();
        disp_req = 1'b0;
        vectors++;
        if (ram_addr !== 10'h005 || ram_we !== 1'b0 || disp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL disp_e0: addr=%h we=%b valid=%b, required 005/0/0", ram_addr, ram_we, disp_valid);
        end
        step();
        vectors++;
        if (disp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL disp_early: disp_valid=%b, required 0", disp_valid);
        end
        step();
        vectors++;
        if (disp_valid !== 1'b1 || disp_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL disp_latency: valid=%b data=%h, required 1/a5", disp_valid, disp_data);
        end
        step();
        vectors++;
        if (disp_valid !== 1'b0 || ram_addr !== 10'h005 || ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL disp_idle_hold: valid=%b addr=%h we=%b, required 0/005/0", disp_valid, ram_addr, ram_we);
        end
    endtask

    task automatic test_cpu_write_read();
        int lat;
        cpu_start(1'b1, 10'h010, 8'h3C);
        step();
        vectors++;
        if (ram_we !== 1'b1 || ram_addr !== 10'h010 || ram_wdata !== 8'h3C) begin
            miscompares++;
            $display("FAIL wr_e0: we=%b addr=%h wdata=%h, required 1/010/3c", ram_we, ram_addr, ram_wdata);
        end
        step();
        vectors++;
        if (ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_we_pulse: ram_we=%b, required 0", ram_we);
        end
        step();
        vectors++;
        if (cpu_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_ack_latency: cpu_ack=%b, required 1", cpu_ack);
        end
        cpu_req = 1'b0;
        step();
        vectors++;
        if (cpu_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_ack_pulse: cpu_ack=%b, required 0", cpu_ack);
        end
        cpu_start(1'b0, 10'h010, 8'h00);
        wait_ack(lat);
        vectors++;
        if (lat != 3 || cpu_rdata !== 8'h3C) begin
            miscompares++;
            $display("FAIL rd_010: latency=%0d rdata=%h, required 3/3c", lat, cpu_rdata);
        end
        cpu_start(1'b1, 10'h3FF, 8'hC3);
        wait_ack(lat);
        cpu_start(1'b0, 10'h3FF, 8'h00);
        wait_ack(lat);
        vectors++;
        if (lat != 3 || cpu_rdata !== 8'hC3) begin
            miscompares++;
            $display("FAIL rd_3ff: latency=%0d rdata=%h, required 3/c3", lat, cpu_rdata);
        end
    endtask

    task automatic test_starvation();
        int  miss_k = 0;
        int  ack_k = 0;
        int  m0 = miss_seen;
        int  d0 = dv_seen;
        bit  acked = 1'b0;
        display_on = 1'b1;
        cpu_start(1'b0, 10'h010, 8'h00);
        for (int k = 1; k <= 24; k++) begin
            disp_req  = 1'b1;
            disp_addr = 10'(k);
            cpu_req   = !acked;
            if (k != 17) disp_exp.push_back(shadow[k]);
            step();
            if (disp_miss === 1'b1 && miss_k == 0) miss_k = k;
            if (cpu_ack === 1'b1 && !acked) begin
                ack_k = k;
                acked = 1'b1;
            end
        end
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        repeat (4) step();
        vectors++;
        if (miss_k != 17 || miss_seen - m0 != 1) begin
            miscompares++;
            $display("FAIL starve_miss: cycle=%0d pulses=%0d, required 17/1", miss_k, miss_seen - m0);
        end
        vectors++;
        if (ack_k != 19) begin
            miscompares++;
            $display("FAIL starve_ack: ack after cycle %0d, required 19", ack_k);
        end
        vectors++;
        if (dv_seen - d0 != 23 || disp_exp.size() != 0 || cpu_exp.size() != 0) begin
            miscompares++;
            $display("FAIL starve_drain: valids=%0d pending=%0d/%0d, required 23/0/0",
                     dv_seen - d0, disp_exp.size(), cpu_exp.size());
        end
    endtask

    task automatic test_display_off();
        int lat;
        int d0 = dv_seen;
        display_on = 1'b0;
        disp_req   = 1'b1;
        disp_addr  = 10'h020;
        cpu_start(1'b0, 10'h3FF, 8'h00);
        wait_ack(lat);
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL dispoff_cpu_latency: got %0d, required 3", lat);
        end
        repeat (3) step();
        vectors++;
        if (ram_we !== 1'b0 || ram_addr !== 10'h3FF || dv_seen != d0) begin
            miscompares++;
            $display("FAIL dispoff_idle: we=%b addr=%h valids=%0d, required 0/3ff/0", ram_we, ram_addr, dv_seen - d0);
        end
        disp_req   = 1'b0;
        display_on = 1'b1;
    endtask

    task automatic test_cpu_drop();
        int miss_k = 0;
        int ack_k = 0;
        int acks = 0;
        bit acked = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 10'h010;
        for (int k = 1; k <= 32; k++) begin
            if (k == 10) cpu_start(1'b0, 10'h010, 8'h00);
            cpu_req   = (k <= 8) ? 1'b1 : (k == 9) ? 1'b0 : !acked;
            disp_req  = 1'b1;
            disp_addr = 10'(k + 100);
            if (k != 26) disp_exp.push_back(shadow[k + 100]);
            step();
            if (disp_miss === 1'b1 && miss_k == 0) miss_k = k;
            if (cpu_ack === 1'b1) begin
                acks++;
                if (!acked) ack_k = k;
                acked = 1'b1;
            end
        end
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        repeat (4) step();
        vectors++;
        if (miss_k != 26 || ack_k != 28 || acks != 1) begin
            miscompares++;
            $display("FAIL drop_rearm: miss=%0d ack=%0d acks=%0d, required 26/28/1", miss_k, ack_k, acks);
        end
        vectors++;
        if (disp_exp.size() != 0 || cpu_exp.size() != 0) begin
            miscompares++;
            $display("FAIL drop_drain: pending=%0d/%0d, required 0/0", disp_exp.size(), cpu_exp.size());
        end
    endtask

    task automatic test_reset_midflight();
        int       lat;
        cpu_exp_t e;
        display_on = 1'b0;
        cpu_start(1'b0, 10'h010, 8'h00);
        step();
        reset = 1'b0;
        disp_exp.delete();
        cpu_exp.delete();
        #1;
        vectors++;
        if ({ram_addr, ram_we, ram_wdata, disp_valid, disp_data, disp_miss, cpu_ack, cpu_rdata} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h, required 0",
                     {ram_addr, ram_we, ram_wdata, disp_valid, disp_data, disp_miss, cpu_ack, cpu_rdata});
        end
        step();
        step();
        vectors++;
        if (cpu_ack !== 1'b0 || disp_valid !== 1'b0 || ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_hold: ack=%b valid=%b we=%b, required 0/0/0", cpu_ack, disp_valid, ram_we);
        end
        reset  = 1'b1;
        e.we   = 1'b0;
        e.data = shadow[10'h010];
        cpu_exp.push_back(e);
        wait_ack(lat);
        vectors++;
        if (lat != 3 || cpu_rdata !== 8'h3C) begin
            miscompares++;
            $display("FAIL midreset_rearb: latency=%0d rdata=%h, required 3/3c", lat, cpu_rdata);
        end
        display_on = 1'b1;
    endtask

`ifdef VRAM_ARB_STATS_EN
    task automatic test_stats();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        vectors++;
        if (conflict_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_clear0: got %0d, required 0", conflict_cnt);
        end
        display_on = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 10'h010;
        for (int k = 0; k < 5; k++) begin
            disp_req  = 1'b1;
            disp_addr = 10'(200 + k);
            cpu_req   = 1'b1;
            disp_exp.push_back(shadow[200 + k]);
            step();
        end
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        step();
        vectors++;
        if (conflict_cnt !== 16'd5) begin
            miscompares++;
            $display("FAIL stats_count: got %0d, required 5", conflict_cnt);
        end
        disp_req    = 1'b1;
        disp_addr   = 10'd210;
        cpu_req     = 1'b1;
        frame_start = 1'b1;
        disp_exp.push_back(shadow[210]);
        step();
        disp_req    = 1'b0;
        cpu_req     = 1'b0;
        frame_start = 1'b0;
        vectors++;
        if (conflict_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_frame_start: got %0d, required 0", conflict_cnt);
        end
        repeat (4) step();
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
        test_reset();
        test_disp_fetch();
        test_cpu_write_read();
        test_starvation();
        test_display_off();
        test_cpu_drop();
        test_reset_midflight();
`ifdef VRAM_ARB_STATS_EN
        test_stats();
`endif
        repeat (4) step();
        vectors++;
        if (disp_exp.size() != 0 || cpu_exp.size() != 0) begin
            miscompares++;
            $display("FAIL final_drain: pending=%0d/%0d, required 0/0", disp_exp.size(), cpu_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
